pipe_ctrl: RTL

Pipeline control unit for the OPEN_MIPS five-stage core. It takes stall requests from the ID and EX stages and the exception type from the MEM stage. From these it drives the 6-bit `stall` vector, the `flush` strobe and the exception-target `new_pc` that sequence the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A post-flush shadow state, a stall watchdog and optional performance counters give it sequential behaviour.

---
 rtl/pipe_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: OPEN_MIPS five-stage stall/flush/redirect control with post-flush
// shadow, sticky stall watchdog and optional perf counters (`PIPE_CTRL_PERF_EN).
module pipe_ctrl #(
    parameter int          STALL_TIMEOUT = 64,
    parameter logic [31:0] EXCEP_VECTOR  = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic [31:0] excep_type,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        flush_shadow,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flush_count
);
    localparam int          CW     = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] WD_MAX = CW'(STALL_TIMEOUT);
    localparam logic [0:0]  RUN    = 1'b0;
    localparam logic [0:0]  SHADOW = 1'b1;
    localparam logic [31:0] ERET   = 32'h0000_000e;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_q, timeout_d;
    logic          excep;

    // Exception beats EX beats ID; the shadow cycle drops stall requests since ID/EX hold bubbles
    always_comb begin
        excep     = rst_n && (excep_type != '0);
        flush     = excep;
        stall     = (!rst_n || excep || state_q == SHADOW) ? 6'b000000 :
                    stallreq_from_ex ? 6'b001111 :
                    stallreq_from_id ? 6'b000111 : 6'b000000;
        new_pc    = !excep ? 32'h0 : (excep_type == ERET) ? cp0_epc : EXCEP_VECTOR;
        state_d   = excep ? SHADOW : RUN;
        wd_cnt_d  = !stall[0] ? '0 : (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + CW'(1);
        timeout_d = timeout_q | (wd_cnt_d == WD_MAX);
    end

    // Shadow state, watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign flush_shadow  = (state_q == SHADOW);
    assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    // Free-running, wrapping event counters for the cycle just ending
    always_comb begin
        perf_stall_d = perf_stall_q + 32'(stall[0]);
        perf_flush_d = perf_flush_q + 16'(flush);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_flush_count  = 16'h0;
`endif
endmodule
